// File: rtl/mapped_io_bank_if.sv
// CPU memory-bus view of an I/O bank: command, address and write data from the CPU,
// with the bank returning combinational read data and a drive enable for the shared read bus.
interface mapped_io_bank_if;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        read_en;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, read_en
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, read_en
    );
endinterface

// File: rtl/mapped_io_bank.sv
// Memory-mapped I/O bank: synchronised inputs, LED output register, W1C rising-edge status, masked irq.
// Latency: reads are combinational in the same cycle; writes land at the clock edge; input rises reach status SYNC_STAGES+1 edges after sampling.
// Backpressure: none, every bus command completes in its own cycle.
module mapped_io_bank #(
    parameter int          N_IN        = 10,
    parameter int          N_OUT       = 10,
    parameter int          SYNC_STAGES = 2,
    parameter logic [8:0]  IN_ADDR     = 9'h140,
    parameter logic [8:0]  OUT_ADDR    = 9'h100,
    parameter logic [8:0]  STAT_ADDR   = 9'h141,
    parameter logic [8:0]  MASK_ADDR   = 9'h142
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   SW,
    mapped_io_bank_if.slave   bus,
    output logic [N_OUT-1:0]  LEDR,
    output logic              irq
);

    localparam logic [1:0] MREAD   = 2'b01;
    localparam logic [1:0] MWRITE  = 2'b10;
    localparam logic [2:0] ARM_CNT = 3'(SYNC_STAGES + 1);

    if (IN_ADDR == OUT_ADDR || IN_ADDR == STAT_ADDR || IN_ADDR == MASK_ADDR ||
        OUT_ADDR == STAT_ADDR || OUT_ADDR == MASK_ADDR || STAT_ADDR == MASK_ADDR) begin : g_addr_clash
        $error("mapped_io_bank: address parameters must be distinct");
    end
    if (N_IN < 1 || N_IN > 16 || N_OUT < 1 || N_OUT > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_width
        $error("mapped_io_bank: parameter out of range");
    end

    logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q, sync_d;
    logic [N_IN-1:0]  prev_q, prev_d;
    logic [N_IN-1:0]  status_q, status_d;
    logic [N_IN-1:0]  mask_q, mask_d;
    logic [N_OUT-1:0] out_reg_q, out_reg_d;
    logic [2:0]       arm_cnt_q, arm_cnt_d;

    logic [N_IN-1:0]  sync_val;
    logic [N_IN-1:0]  new_rise;
    logic             armed;
    logic             wr_vld;
    logic             rd_vld;
    logic [15:0]      rd_dat;
    logic             rd_hit;
    logic             unused_wd;

    assign unused_wd = ^bus.write_data;
    assign sync_val  = sync_q[SYNC_STAGES-1];
    assign armed     = (arm_cnt_q == ARM_CNT);
    // Rises seen before the synchroniser has flushed its reset zeros are not real edges.
    assign new_rise  = armed ? (sync_val & ~prev_q) : '0;
    assign wr_vld    = (bus.mem_cmd == MWRITE);
    assign rd_vld    = (bus.mem_cmd == MREAD);

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = SW;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d    = sync_val;
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
        out_reg_d = out_reg_q;
        mask_d    = mask_q;
        status_d  = status_q | new_rise;
        if (wr_vld) begin
            if (bus.mem_addr == OUT_ADDR)  out_reg_d = bus.write_data[N_OUT-1:0];
            if (bus.mem_addr == MASK_ADDR) mask_d    = bus.write_data[N_IN-1:0];
            // A rise in the clearing cycle survives the clear.
            if (bus.mem_addr == STAT_ADDR) status_d  = (status_q & ~bus.write_data[N_IN-1:0]) | new_rise;
        end
    end

    always_comb begin
        rd_dat = '0;
        rd_hit = 1'b0;
        if (rd_vld) begin
            if (bus.mem_addr == IN_ADDR) begin
                rd_hit            = 1'b1;
                rd_dat[N_IN-1:0]  = sync_val;
            end else if (bus.mem_addr == OUT_ADDR) begin
                rd_hit            = 1'b1;
                rd_dat[N_OUT-1:0] = out_reg_q;
            end else if (bus.mem_addr == STAT_ADDR) begin
                rd_hit            = 1'b1;
                rd_dat[N_IN-1:0]  = status_q;
            end else if (bus.mem_addr == MASK_ADDR) begin
                rd_hit            = 1'b1;
                rd_dat[N_IN-1:0]  = mask_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            prev_q    <= '0;
            status_q  <= '0;
            mask_q    <= '0;
            out_reg_q <= '0;
            arm_cnt_q <= '0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            status_q  <= status_d;
            mask_q    <= mask_d;
            out_reg_q <= out_reg_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    assign bus.read_data = rd_dat;
    assign bus.read_en   = rd_hit;
    assign LEDR          = out_reg_q;
    assign irq           = |(status_q & mask_q);

endmodule
